// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron evaluation slice: operand widths,
// sample count, index helpers and the evaluation FSM state encoding.
package perceptron_pkg;

  // Default signed width of weights and bias.
  localparam int W = 8;

  // Sum width: bias plus two weights can grow by at most two bits.
  localparam int SUM_W = W + 2;

  // Number of samples in the two-input truth table.
  localparam int N_SAMPLES = 4;

  // Width of the sample index (log2 of N_SAMPLES).
  localparam int IDX_W = 2;

  // Width of the correct-sample counter (must hold 0..N_SAMPLES).
  localparam int CNT_W = 3;

  // Evaluation FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the index addresses the final sample of the table.
  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_SAMPLES - 1));
  endfunction

  // Next value of the correct-sample counter given a match flag.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                   input logic            hit);
    logic [CNT_W-1:0] res;
    if (hit) begin
      res = cnt + 3'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/perceptron_neuron.sv
// Two-input perceptron neuron: sum = bias + x0*w0 + x1*w1, y = (sum >= THRESHOLD).
// Purely combinational so the same block can sit in the training datapath.
// All operands are sign-extended by two bits, which makes the sum exact for
// every combination of W-bit inputs (no wrap, no saturation).
module perceptron_neuron #(
  parameter int W         = perceptron_pkg::W,
  parameter int THRESHOLD = 0
) (
  input  logic         x0,
  input  logic         x1,
  input  logic [W-1:0] w0,
  input  logic [W-1:0] w1,
  input  logic [W-1:0] bias,
  output logic [W+1:0] sum,
  output logic         y
);

  logic [W+1:0]        bias_ext_s;
  logic [W+1:0]        term0_s;
  logic [W+1:0]        term1_s;
  logic signed [31:0]  sum_ext_s;

  // Sign-extend the operands and gate each weight by its input bit.
  always_comb begin
    bias_ext_s = {{2{bias[W-1]}}, bias};
    if (x0) begin
      term0_s = {{2{w0[W-1]}}, w0};
    end else begin
      term0_s = {(W+2){1'b0}};
    end
    if (x1) begin
      term1_s = {{2{w1[W-1]}}, w1};
    end else begin
      term1_s = {(W+2){1'b0}};
    end
  end

  // Exact weighted sum and signed threshold compare (done at 32 bits so any
  // integer THRESHOLD compares correctly against the narrower sum).
  always_comb begin
    sum       = bias_ext_s + term0_s + term1_s;
    sum_ext_s = {{(32-W-2){sum[W+1]}}, sum};
    y         = (sum_ext_s >= THRESHOLD);
  end

endmodule

// File: rtl/perceptron_eval.sv
// Perceptron truth-table evaluator. On an accepted start it latches the
// weights, bias and expected outputs, walks the four input combinations
// (x0 = idx[0], x1 = idx[1]) one per cycle through perceptron_neuron, and
// reports the per-sample outputs, the number that matched the targets and
// an all-correct flag. Results hold until the next accepted start.
module perceptron_eval #(
  parameter int W         = perceptron_pkg::W,
  parameter int THRESHOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] w0,
  input  logic [W-1:0] w1,
  input  logic [W-1:0] bias,
  input  logic [3:0]   targets,
  output logic         busy,
  output logic         done,
  output logic [3:0]   y_vec,
  output logic [2:0]   n_correct,
  output logic         all_correct
);

  import perceptron_pkg::*;

  // Sum width derived from this instance's weight width.
  localparam int SUM_W_L = W + 2;

  // FSM and sample index.
  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;

  // Operands captured when start is accepted; inputs are ignored afterwards.
  logic [W-1:0]       w0_r;
  logic [W-1:0]       w1_r;
  logic [W-1:0]       bias_r;
  logic [3:0]         targets_r;

  // Result and status registers.
  logic [3:0]         y_vec_r;
  logic [CNT_W-1:0]   n_correct_r;
  logic               busy_r;
  logic               done_r;

  // Neuron interface for the sample currently being evaluated.
  logic               x0_s;
  logic               x1_s;
  logic               y_s;
  logic               hit_s;
  logic               last_s;
  // The exact sum is only needed inside the neuron for the compare; it is
  // kept on a named net so it can be observed, but no logic here consumes it.
  logic [SUM_W_L-1:0] sum_unused_s;

  assign x0_s   = idx_r[0];
  assign x1_s   = idx_r[1];
  assign hit_s  = (y_s == targets_r[idx_r]);
  assign last_s = is_last_idx(idx_r);

  perceptron_neuron #(
    .W         (W),
    .THRESHOLD (THRESHOLD)
  ) u_neuron (
    .x0   (x0_s),
    .x1   (x1_s),
    .w0   (w0_r),
    .w1   (w1_r),
    .bias (bias_r),
    .sum  (sum_unused_s),
    .y    (y_s)
  );

  // Evaluation FSM: accept start in IDLE, four EVAL cycles, one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      w0_r        <= {W{1'b0}};
      w1_r        <= {W{1'b0}};
      bias_r      <= {W{1'b0}};
      targets_r   <= 4'b0000;
      y_vec_r     <= 4'b0000;
      n_correct_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            w0_r        <= w0;
            w1_r        <= w1;
            bias_r      <= bias;
            targets_r   <= targets;
            y_vec_r     <= 4'b0000;
            n_correct_r <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= ST_EVAL;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_EVAL: begin
          y_vec_r[idx_r] <= y_s;
          n_correct_r    <= next_count(n_correct_r, hit_s);
          if (last_s) begin
            idx_r   <= {IDX_W{1'b0}};
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + 2'd1;
            done_r  <= 1'b0;
            state_r <= ST_EVAL;
          end
        end

        ST_DONE: begin
          // Start is deliberately not sampled here: a held start produces
          // one IDLE cycle before the next pass.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          idx_r   <= {IDX_W{1'b0}};
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign y_vec       = y_vec_r;
  assign n_correct   = n_correct_r;
  assign all_correct = (n_correct_r == 3'd4);

endmodule

// File: tb/tb_perceptron_eval.sv
// Self-checking bench for perceptron_eval: directed vector table, random
// passes against a behavioural truth-table model, and hand-written sequences
// for start-in-EVAL, mid-pass reset and held start.
module tb_perceptron_eval;

  localparam int W   = 8;
  localparam int THR = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] w0, w1, bias;
  logic [3:0] targets;
  logic       busy, done;
  logic [3:0] y_vec;
  logic [2:0] n_correct;
  logic       all_correct;

  perceptron_eval #(.W(W), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .w0(w0), .w1(w1), .bias(bias),
    .targets(targets), .busy(busy), .done(done), .y_vec(y_vec),
    .n_correct(n_correct), .all_correct(all_correct)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model results.
  logic [3:0] m_y;
  int         m_n;
  int         m_sum[4];

  // Truth-table evaluation straight from the arithmetic definition.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [3:0] t);
    m_n = 0;
    for (int i = 0; i < 4; i++) begin
      int s;
      s = $signed(c);
      if (i % 2 == 1) s = s + $signed(a);
      if (i / 2 == 1) s = s + $signed(b);
      m_sum[i] = s;
      m_y[i]   = (s >= THR);
      if (m_y[i] == t[i]) m_n++;
    end
  endtask

  // Observations from the last pass.
  logic [3:0] g_y, g_y_after;
  int g_n, g_all, g_lat, g_busy, g_done_after, g_busy_after, g_n_after;
  int g_sum[4];

  // One start pulse; edges counted including the accepting edge.
  task automatic run_pass(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [3:0] t);
    int edges;
    @(negedge clk);
    w0 = a; w1 = b; bias = c; targets = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 20) begin
      if (edges <= 4) g_sum[edges-1] = $signed(dut.u_neuron.sum);
      // Scramble the live inputs: only the latched copies may matter.
      w0 = 8'($urandom); w1 = 8'($urandom); bias = 8'($urandom);
      targets = 4'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    g_lat = edges; g_y = y_vec; g_n = n_correct; g_all = all_correct; g_busy = busy;
    @(posedge clk); #1;
    g_done_after = done; g_busy_after = busy; g_y_after = y_vec; g_n_after = n_correct;
  endtask

  task automatic check_pass(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [3:0] t,
                            input logic [3:0] ey, input int en);
    model(a, b, c, t);
    run_pass(a, b, c, t);
    check({name, " latency"}, g_lat, 5);
    check({name, " y_vec"}, g_y, ey);
    check({name, " n_correct"}, g_n, en);
    check({name, " all_correct"}, g_all, (en == 4) ? 1 : 0);
    check({name, " busy@done"}, g_busy, 1);
    check({name, " done after"}, g_done_after, 0);
    check({name, " busy after"}, g_busy_after, 0);
    check({name, " y_vec hold"}, g_y_after, ey);
    check({name, " n hold"}, g_n_after, en);
    for (int i = 0; i < 4; i++) check($sformatf("%s sum%0d", name, i), g_sum[i], m_sum[i]);
  endtask

  typedef struct {
    string      name;
    logic [7:0] w0, w1, bias;
    logic [3:0] tgt, ey;
    int         en;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt, first, second;
    logic [3:0] sy;
    int sn;

    rst = 1'b1; start = 1'b0; w0 = 8'h00; w1 = 8'h00; bias = 8'h00; targets = 4'b0000;

    tbl[0] = '{"and",     8'h01, 8'h01, 8'hFE, 4'b1000, 4'b1000, 4};
    tbl[1] = '{"or_like", 8'h01, 8'h01, 8'hFF, 4'b1000, 4'b1110, 2};
    tbl[2] = '{"min",     8'h80, 8'h80, 8'h80, 4'b0000, 4'b0000, 4};
    tbl[3] = '{"max",     8'h7F, 8'h7F, 8'h7F, 4'b0000, 4'b1111, 0};
    tbl[4] = '{"zero_eq", 8'h00, 8'h00, 8'h00, 4'b1111, 4'b1111, 4};
    tbl[5] = '{"neg1",    8'h00, 8'h00, 8'hFF, 4'b1111, 4'b0000, 0};
    tbl[6] = '{"mixed",   8'h03, 8'hFD, 8'h00, 4'b0110, 4'b1011, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst y_vec", y_vec, 0);
    check("rst n_correct", n_correct, 0);
    check("rst all_correct", all_correct, 0);
    @(negedge clk); rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++)
      check_pass(tbl[i].name, tbl[i].w0, tbl[i].w1, tbl[i].bias, tbl[i].tgt, tbl[i].ey, tbl[i].en);

    // Random passes against the model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b, c;
      logic [3:0] t;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); t = 4'($urandom);
      model(a, b, c, t);
      check_pass($sformatf("rand%0d", i), a, b, c, t, m_y, m_n);
    end

    // Start pulsed again in EVAL, w0 changed in the second EVAL cycle.
    @(negedge clk);
    w0 = 8'h01; w1 = 8'h01; bias = 8'hFF; targets = 4'b1000; start = 1'b1;
    @(posedge clk); #1;          // accepted; first EVAL cycle, start still high
    @(posedge clk); #1;          // second EVAL cycle
    start = 1'b0; w0 = 8'h9C;
    cnt = 0; sy = 4'b0000; sn = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cnt++; sy = y_vec; sn = n_correct;
      end
    end
    check("restart done count", cnt, 1);
    check("restart y_vec", sy, 4'b1110);
    check("restart n_correct", sn, 2);

    // Reset asserted in the third EVAL cycle.
    @(negedge clk);
    w0 = 8'h05; w1 = 8'h05; bias = 8'h0A; targets = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-rst y_vec", y_vec, 4'b0011);
    check("pre-rst n_correct", n_correct, 2);
    check("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst y_vec", y_vec, 0);
    check("mid rst n_correct", n_correct, 0);
    check("mid rst all_correct", all_correct, 0);
    @(negedge clk); rst = 1'b0;
    check_pass("post_rst", 8'h01, 8'h01, 8'hFE, 4'b1000, 4'b1000, 4);

    // Start held high for 12 cycles.
    @(negedge clk);
    w0 = 8'h01; w1 = 8'h01; bias = 8'hFE; targets = 4'b1000; start = 1'b1;
    cnt = 0; first = -1; second = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 11) start = 1'b0;
      if (done === 1'b1) begin
        if (cnt == 0) first = k;
        else if (cnt == 1) second = k;
        cnt++;
      end
    end
    check("held done count", cnt, 2);
    check("held done gap", second - first, 6);
    check("held first done", first, 4);
    check("held y_vec", y_vec, 4'b1000);
    check("held all_correct", all_correct, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
